midi_rx_parser: RTL and testbench
=================================

MIDI_RX_PARSER -- requirements
Module: midi_rx_parser

Interface
REQ-001 Parameter CLK_HZ, default 25000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 31250, MIDI bit rate; oversample divider = CLK_HZ/(BAUD*16), 50 at defaults.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 CLOCK_25  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 midi_rxd  input  1  raw MIDI serial line, idle high, asynchronous to CLOCK_25.
REQ-007 byteready  output  1  one-cycle pulse: midi_data_byte, cur_status and midibyte_nr are valid and updated.
REQ-008 midi_data_byte  output  8  last accepted byte.
REQ-009 cur_status  output  8  current running status; 0 = none.
REQ-010 midibyte_nr  output  8  position of the current byte in its message; 0 = status byte.
REQ-011 frame_error  output  1  one-cycle pulse on bad stop bit.
REQ-012 sysex_active  output  1  high between accepted F0 and F7.

Function
REQ-013 midi_rxd SHALL pass a 2-flop synchronizer before any use.
REQ-014 A tick counter SHALL produce one enable every divider cycles (16x bit rate), free-running except when cleared on start detection.
REQ-015 UART FSM states: WAIT_HIGH, IDLE, START, DATA, STOP.
REQ-016 WAIT_HIGH -> IDLE when the synchronized line is high.
REQ-017 IDLE -> START when the synchronized line is low; the tick counter clears.
REQ-018 START: at tick 8, line low -> DATA; line high -> IDLE (glitch reject, no output).
REQ-019 DATA: 8 bits sampled every 16 ticks from mid-start, LSB first, into a shift register.
REQ-020 STOP: sampled 16 ticks after bit 7.
REQ-021 Stop high: byte goes to the parser and FSM returns to IDLE.
REQ-022 Stop low: byte dropped, frame_error pulses, FSM goes to WAIT_HIGH.
REQ-023 Parser output appears the cycle after the stop sample (latency 1); byteready and all updated fields change in that same cycle.
REQ-024 Channel status 80-EF: cur_status=byte, midibyte_nr=0, byteready pulses.
REQ-025 Data byte (bit7=0), cur_status in 80-EF: midibyte_nr increments.
REQ-026 Data-byte counts for running status: 8x/9x/Ax/Bx/Ex wrap 2->1; Cx/Dx hold at 1.
REQ-027 Data byte with cur_status=0 SHALL be dropped silently.
REQ-028 F0: cur_status=F0, midibyte_nr=0, sysex_active=1, byteready pulses.
REQ-029 Data bytes while sysex_active: midibyte_nr increments, saturating at FF.
REQ-030 F7: byteready pulses, sysex_active=0, cur_status=0, midibyte_nr=0.
REQ-031 F1-F6: byteready pulses, cur_status=0 (running status cancelled), sysex_active=0.
REQ-032 Realtime F8-FF never alter cur_status, midibyte_nr or sysex_active, including mid-message.

Reset
REQ-033 While reset is high: all outputs 0, synchronizer flops 1, counters 0, FSM in WAIT_HIGH.
REQ-034 Reset mid-frame SHALL abandon the partial byte with no byteready or frame_error pulse; reception resumes only after the line is seen high.

Configuration
REQ-035 Macro MIDI_RX_REALTIME_FILTER_EN: defined -> F8-FF accepted and discarded, no byteready.
REQ-036 Macro not defined -> F8-FF pulse byteready with midi_data_byte=byte and cur_status/midibyte_nr unchanged.

Verification
REQ-037 Bytes 90 3C 64 at 31250 baud -> 3 pulses; cur_status 90 throughout; midibyte_nr 0,1,2; last midi_data_byte 64.
REQ-038 After REQ-037, send 3E 00 -> midibyte_nr 1,2; cur_status stays 90.
REQ-039 Send C5 07 09 -> midibyte_nr 0,1,1.
REQ-040 Send 90 3C, then F8, then 40, with the macro defined -> F8 gives no pulse; 40 has midibyte_nr 2. Without the macro, F8 pulses and 40 still has midibyte_nr 2.
REQ-041 Frame with stop bit 0, then idle -> frame_error pulses once, no byteready; next valid 80 gives cur_status 80.
REQ-042 Assert reset during bit 4 of a byte -> no pulses; all outputs 0. After release with the line low, no start until the line goes high; then F0 01 F7 -> sysex_active 1 then 0, midibyte_nr 0,1,0.

Source files
------------

// File: rtl/midi_rx_parser.sv
// MIDI serial receiver (16x oversampled UART) feeding a running-status message parser.
// Define MIDI_RX_REALTIME_FILTER_EN to swallow realtime bytes F8-FF without a byteready pulse.
module midi_rx_parser #(
  parameter int CLK_HZ = 25000000,
  parameter int BAUD   = 31250
) (
  input  logic       CLOCK_25,
  input  logic       reset,
  input  logic       midi_rxd,
  output logic       byteready,
  output logic [7:0] midi_data_byte,
  output logic [7:0] cur_status,
  output logic [7:0] midibyte_nr,
  output logic       frame_error,
  output logic       sysex_active
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef MIDI_RX_REALTIME_FILTER_EN
  localparam bit RT_PASS = 1'b0;
`else
  localparam bit RT_PASS = 1'b1;
`endif

  typedef enum logic [2:0] {WAIT_HIGH, IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nxt;
  logic               rxd_p0, rxd_p1;
  logic [DIV_W-1:0]   div_cnt;
  logic [3:0]         tick_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg_p2;
  logic               tick, line;
  logic               cnt_clr, cnt_en, phase_end, sample_bit, vld_p2, ferr_p2;

  function automatic logic [7:0] sat_inc(input logic [7:0] nr);
    return (nr == 8'hFF) ? nr : nr + 8'd1;
  endfunction

  // Cx/Dx carry one data byte per message; the rest carry two and wrap back to 1.
  function automatic logic [7:0] chan_nr_next(input logic [7:0] status, input logic [7:0] nr);
    if (status[7:4] == 4'hC || status[7:4] == 4'hD) return 8'd1;
    else if (nr >= 8'd2)                            return 8'd1;
    else                                            return nr + 8'd1;
  endfunction

  // Stage 0/1: two-flop synchronizer, idles high.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
    end else begin
      rxd_p0 <= midi_rxd;
      rxd_p1 <= rxd_p0;
    end
  end

  assign line = rxd_p1;
  assign tick = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      if (cnt_clr || tick) div_cnt <= '0;
      else                 div_cnt <= div_cnt + DIV_W'(1);
      if (cnt_clr || phase_end) tick_cnt <= '0;
      else if (cnt_en)          tick_cnt <= tick_cnt + 4'd1;
      if (cnt_clr)         bit_cnt <= '0;
      else if (sample_bit) bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // Stage 2: LSB-first shift register, loaded at each mid-bit sample.
  always_ff @(posedge CLOCK_25) begin
    if (sample_bit) shreg_p2 <= {line, shreg_p2[7:1]};
  end

  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) state <= WAIT_HIGH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_HIGH: if (tick && line) state_nxt = IDLE;
      IDLE:      if (!line)        state_nxt = START;
      START:     if (phase_end)    state_nxt = line ? IDLE : DATA;
      DATA:      if (phase_end && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:      if (phase_end)    state_nxt = line ? IDLE : WAIT_HIGH;
      default:                     state_nxt = WAIT_HIGH;
    endcase
  end

  // Waiting for the line to be high on a tick keeps reset-release (sync flops at 1) from faking an idle line.
  always_comb begin
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    phase_end  = 1'b0;
    sample_bit = 1'b0;
    vld_p2     = 1'b0;
    ferr_p2    = 1'b0;
    case (state)
      IDLE:  cnt_clr = !line;
      START: begin
        cnt_en    = tick;
        phase_end = tick && (tick_cnt == 4'd7);
      end
      DATA: begin
        cnt_en     = tick;
        phase_end  = tick && (tick_cnt == 4'd15);
        sample_bit = phase_end;
      end
      STOP: begin
        cnt_en    = tick;
        phase_end = tick && (tick_cnt == 4'd15);
        vld_p2    = phase_end && line;
        ferr_p2   = phase_end && !line;
      end
      default: ;
    endcase
  end

  // Stage 3: message parser, registered outputs one cycle after the stop sample.
  always_ff @(posedge CLOCK_25 or posedge reset) begin
    if (reset) begin
      byteready      <= 1'b0;
      frame_error    <= 1'b0;
      midi_data_byte <= 8'h00;
      cur_status     <= 8'h00;
      midibyte_nr    <= 8'h00;
      sysex_active   <= 1'b0;
    end else begin
      byteready   <= 1'b0;
      frame_error <= ferr_p2;
      if (vld_p2) begin
        if (shreg_p2 >= 8'hF8) begin
          if (RT_PASS) begin
            byteready      <= 1'b1;
            midi_data_byte <= shreg_p2;
          end
        end else if (shreg_p2[7]) begin
          byteready      <= 1'b1;
          midi_data_byte <= shreg_p2;
          midibyte_nr    <= 8'h00;
          if (shreg_p2 == 8'hF0) begin
            cur_status   <= 8'hF0;
            sysex_active <= 1'b1;
          end else if (shreg_p2 >= 8'hF1) begin
            cur_status   <= 8'h00;
            sysex_active <= 1'b0;
          end else begin
            cur_status   <= shreg_p2;
            sysex_active <= 1'b0;
          end
        end else if (sysex_active) begin
          byteready      <= 1'b1;
          midi_data_byte <= shreg_p2;
          midibyte_nr    <= sat_inc(midibyte_nr);
        end else if (cur_status[7] && cur_status < 8'hF0) begin
          byteready      <= 1'b1;
          midi_data_byte <= shreg_p2;
          midibyte_nr    <= chan_nr_next(cur_status, midibyte_nr);
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Bench for midi_rx_parser: byte table driven as serial frames, scoreboard checks parser pulses.
module tb_midi_rx_parser;

  localparam int CLK_HZ = 2000000;
  localparam int BAUD   = 31250;
  localparam int BIT    = 16 * (CLK_HZ / (BAUD * 16));

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       byteready, frame_error, sysex_active;
  logic [7:0] midi_data_byte, cur_status, midibyte_nr;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       out;
    logic       ferr;
    logic [7:0] st;
    logic [7:0] nr;
    logic       sx;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  midi_rx_parser #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .CLOCK_25(clk), .reset(rst), .midi_rxd(rxd),
    .byteready(byteready), .midi_data_byte(midi_data_byte), .cur_status(cur_status),
    .midibyte_nr(midibyte_nr), .frame_error(frame_error), .sysex_active(sysex_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] b, input logic stop, input logic out,
                              input logic ferr, input logic [7:0] st, input logic [7:0] nr,
                              input logic sx);
    vec_t v;
    v.b = b; v.stop = stop; v.out = out; v.ferr = ferr; v.st = st; v.nr = nr; v.sx = sx;
    return v;
  endfunction

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (byteready || frame_error) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got byteready=%0b frame_error=%0b data=%02h expected none",
                 byteready, frame_error, midi_data_byte);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk($sformatf("kind_%02h", e.b), {6'd0, byteready, frame_error}, {6'd0, !e.ferr, e.ferr});
        if (!e.ferr) begin
          chk($sformatf("data_%02h", e.b), midi_data_byte, e.b);
          chk($sformatf("status_%02h", e.b), cur_status, e.st);
          chk($sformatf("nr_%02h", e.b), midibyte_nr, e.nr);
          chk($sformatf("sysex_%02h", e.b), {7'd0, sysex_active}, {7'd0, e.sx});
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(b[i], BIT);
    drive(stop, BIT);
    drive(1'b1, 2 * BIT);
  endtask

  task automatic send_vec(input vec_t v);
    if (v.out) sb.push_back(v);
    send_frame(v.b, v.stop);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byteready"}, {7'd0, byteready}, 8'h00);
    chk({tag, "_frame_error"}, {7'd0, frame_error}, 8'h00);
    chk({tag, "_sysex"}, {7'd0, sysex_active}, 8'h00);
    chk({tag, "_data"}, midi_data_byte, 8'h00);
    chk({tag, "_status"}, cur_status, 8'h00);
    chk({tag, "_nr"}, midibyte_nr, 8'h00);
  endtask

  initial begin
    logic [7:0] partial;
    // byte, stop, out, ferr, status, nr, sysex
    tbl.push_back(mk(8'h90, 1, 1, 0, 8'h90, 8'd0, 0));
    tbl.push_back(mk(8'h3C, 1, 1, 0, 8'h90, 8'd1, 0));
    tbl.push_back(mk(8'h64, 1, 1, 0, 8'h90, 8'd2, 0));
    tbl.push_back(mk(8'h3E, 1, 1, 0, 8'h90, 8'd1, 0));
    tbl.push_back(mk(8'h00, 1, 1, 0, 8'h90, 8'd2, 0));
    tbl.push_back(mk(8'hC5, 1, 1, 0, 8'hC5, 8'd0, 0));
    tbl.push_back(mk(8'h07, 1, 1, 0, 8'hC5, 8'd1, 0));
    tbl.push_back(mk(8'h09, 1, 1, 0, 8'hC5, 8'd1, 0));
    tbl.push_back(mk(8'h90, 1, 1, 0, 8'h90, 8'd0, 0));
    tbl.push_back(mk(8'h3C, 1, 1, 0, 8'h90, 8'd1, 0));
`ifdef MIDI_RX_REALTIME_FILTER_EN
    tbl.push_back(mk(8'hF8, 1, 0, 0, 8'h90, 8'd1, 0));
`else
    tbl.push_back(mk(8'hF8, 1, 1, 0, 8'h90, 8'd1, 0));
`endif
    tbl.push_back(mk(8'h40, 1, 1, 0, 8'h90, 8'd2, 0));
    tbl.push_back(mk(8'hF3, 1, 1, 0, 8'h00, 8'd0, 0));
    tbl.push_back(mk(8'h12, 1, 0, 0, 8'h00, 8'd0, 0));
    tbl.push_back(mk(8'hF0, 1, 1, 0, 8'hF0, 8'd0, 1));
    tbl.push_back(mk(8'h05, 1, 1, 0, 8'hF0, 8'd1, 1));
    tbl.push_back(mk(8'h06, 1, 1, 0, 8'hF0, 8'd2, 1));
    tbl.push_back(mk(8'hF7, 1, 1, 0, 8'h00, 8'd0, 0));
    tbl.push_back(mk(8'h55, 0, 1, 1, 8'h00, 8'd0, 0));
    tbl.push_back(mk(8'h80, 1, 1, 0, 8'h80, 8'd0, 0));

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    drive(1'b1, 2 * BIT);

    for (int i = 0; i < tbl.size(); i++) send_vec(tbl[i]);

    // Short low glitch must be rejected at mid-start.
    drive(1'b0, 8);
    drive(1'b1, 2 * BIT);
    chk("after_glitch_status", cur_status, 8'h80);

    // Reset in the middle of bit 4, then hold the line low after release.
    partial = 8'hA5;
    drive(1'b0, BIT);
    for (int i = 0; i < 4; i++) drive(partial[i], BIT);
    drive(partial[4], BIT / 2);
    rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk_all_zero("midreset");
    rst = 1'b0;
    drive(1'b0, 3 * BIT);
    chk("held_low_status", cur_status, 8'h00);
    drive(1'b1, 2 * BIT);

    send_vec(mk(8'hF0, 1, 1, 0, 8'hF0, 8'd0, 1));
    send_vec(mk(8'h01, 1, 1, 0, 8'hF0, 8'd1, 1));
    send_vec(mk(8'hF7, 1, 1, 0, 8'h00, 8'd0, 0));

    drive(1'b1, 4 * BIT);
    chk("queue_drained", 8'(sb.size()), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
